// File: rtl/sync_fifo_if.sv
// Handshake and data bundle between a sync_fifo and its producer/consumer.
interface sync_fifo_if #(
  parameter int unsigned WIDTH = 32
);

  logic             wn;
  logic             rn;
  logic [WIDTH-1:0] DATAIN;
  logic [WIDTH-1:0] DATAOUT;
  logic             full;
  logic             empty;

  // Producer/consumer side: drives enables and write data, observes status.
  modport master (
    output wn,
    output rn,
    output DATAIN,
    input  DATAOUT,
    input  full,
    input  empty
  );

  // FIFO side.
  modport slave (
    input  wn,
    input  rn,
    input  DATAIN,
    output DATAOUT,
    output full,
    output empty
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO: DEPTH words, in-order, registered read data.
// Flags are decoded from the occupancy count, so they follow it in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic       clock,
  input  logic       reset,
  sync_fifo_if.slave bus
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic [AW:0]      cnt_next;
  logic [WIDTH-1:0] data_out;
  logic             rd_ok;
  logic             wr_ok;
  logic             is_full;
  logic             is_empty;

  assign is_empty    = (cnt == (AW+1)'(0));
  assign is_full     = (cnt == (AW+1)'(DEPTH));
  assign bus.empty   = is_empty;
  assign bus.full    = is_full;
  assign bus.DATAOUT = data_out;

  // Acceptance: a read frees the slot a same-edge write into a full FIFO uses.
  always_comb begin
    rd_ok    = 1'b0;
    wr_ok    = 1'b0;
    cnt_next = cnt;
    rd_ok    = bus.rn && !is_empty;
    wr_ok    = bus.wn && (!is_full || rd_ok);
    case ({wr_ok, rd_ok})
      2'b10:   cnt_next = cnt + (AW+1)'(1);
      2'b01:   cnt_next = cnt - (AW+1)'(1);
      default: cnt_next = cnt;
    endcase
  end

  // Storage array; not cleared by reset, but reset blocks writes on its edge.
  always_ff @(posedge clock) begin
    if (reset && wr_ok) begin
      mem[wp] <= bus.DATAIN;
    end
  end

  // Pointers, occupancy and the read data register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      data_out <= '0;
    end else begin
      cnt <= cnt_next;
      if (wr_ok) begin
        wp <= wp + AW'(1);
      end
      if (rd_ok) begin
        rp       <= rp + AW'(1);
        data_out <= mem[rp];
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue holds the words the FIFO should hold.
module tb_sync_fifo;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic clock;
  logic reset;

  sync_fifo_if #(.WIDTH(WIDTH)) bus ();

  sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [WIDTH-1:0] sb_q [$];
  logic [WIDTH-1:0] exp_out;
  int               n_cmp;
  int               n_err;

  // Count one comparison and report it if it differs.
  task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                          input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".dataout"}, bus.DATAOUT, exp_out);
    check_eq({tag, ".empty"}, WIDTH'(bus.empty), WIDTH'(sb_q.size() == 0));
    check_eq({tag, ".full"},  WIDTH'(bus.full),  WIDTH'(sb_q.size() == DEPTH));
  endtask

  // One clock edge with the given enables; model is updated from pre-edge state.
  task automatic step(input string tag, input logic w, input logic r,
                      input logic [WIDTH-1:0] d);
    logic rd;
    logic wr;
    bus.wn     = w;
    bus.rn     = r;
    bus.DATAIN = d;
    rd = r && (sb_q.size() != 0);
    wr = w && ((sb_q.size() != DEPTH) || rd);
    @(posedge clock);
    #1;
    if (rd) exp_out = sb_q.pop_front();
    if (wr) sb_q.push_back(d);
    bus.wn = 1'b0;
    bus.rn = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input string tag, input logic w, input logic r);
    reset  = 1'b0;
    bus.wn = w;
    bus.rn = r;
    bus.DATAIN = 32'hDEAD_BEEF;
    @(posedge clock);
    #1;
    reset  = 1'b1;
    bus.wn = 1'b0;
    bus.rn = 1'b0;
    sb_q.delete();
    exp_out = '0;
    check_state(tag);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    exp_out    = '0;
    reset      = 1'b0;
    bus.wn     = 1'b0;
    bus.rn     = 1'b0;
    bus.DATAIN = '0;

    // Reset with enables asserted: reset must win.
    do_reset("reset", 1'b1, 1'b1);

    // Basic order, then a read past empty holds the last word.
    step("w100", 1'b1, 1'b0, 32'd100);
    step("w150", 1'b1, 1'b0, 32'd150);
    step("r1",   1'b0, 1'b1, '0);
    check_eq("r1.value", bus.DATAOUT, 32'd100);
    step("r2",   1'b0, 1'b1, '0);
    check_eq("r2.value", bus.DATAOUT, 32'd150);
    step("r3_empty", 1'b0, 1'b1, '0);
    check_eq("r3.hold", bus.DATAOUT, 32'd150);

    // Fill, overflow drop, drain.
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, WIDTH'(i));
    check_eq("fill.full", WIDTH'(bus.full), WIDTH'(1));
    step("overflow", 1'b1, 1'b0, 32'd99);
    for (int i = 1; i <= 8; i++) begin
      step("drain", 1'b0, 1'b1, '0);
      check_eq("drain.value", bus.DATAOUT, WIDTH'(i));
    end
    check_eq("drain.empty", WIDTH'(bus.empty), WIDTH'(1));

    // Wrap the pointers a few times.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 6; i++) step("wrap.w", 1'b1, 1'b0, WIDTH'($urandom));
      for (int i = 0; i < 6; i++) step("wrap.r", 1'b0, 1'b1, '0);
    end

    // Simultaneous read/write at occupancy 3.
    for (int i = 0; i < 3; i++) step("sim3.w", 1'b1, 1'b0, WIDTH'(32'h300 + i));
    for (int i = 0; i < 4; i++) step("sim3.rw", 1'b1, 1'b1, WIDTH'(32'h400 + i));
    for (int i = 0; i < 3; i++) step("sim3.r", 1'b0, 1'b1, '0);
    check_eq("sim3.last", bus.DATAOUT, 32'h403);

    // Simultaneous read/write while full.
    for (int i = 0; i < 8; i++) step("simf.w", 1'b1, 1'b0, WIDTH'(32'h500 + i));
    step("simf.rw", 1'b1, 1'b1, 32'h5FF);
    check_eq("simf.full", WIDTH'(bus.full), WIDTH'(1));
    check_eq("simf.value", bus.DATAOUT, 32'h500);
    for (int i = 0; i < 8; i++) step("simf.r", 1'b0, 1'b1, '0);
    check_eq("simf.tail", bus.DATAOUT, 32'h5FF);

    // Simultaneous read/write while empty: write only, no fall-through.
    step("sime.rw", 1'b1, 1'b1, 32'h777);
    check_eq("sime.empty", WIDTH'(bus.empty), WIDTH'(0));
    check_eq("sime.hold", bus.DATAOUT, 32'h5FF);
    step("sime.r", 1'b0, 1'b1, '0);
    check_eq("sime.value", bus.DATAOUT, 32'h777);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WIDTH'($urandom));

    // Mid-operation reset discards contents.
    do_reset("pre", 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("mid.w", 1'b1, 1'b0, WIDTH'(32'h600 + i));
    do_reset("mid.reset", 1'b0, 1'b0);
    step("mid.r", 1'b0, 1'b1, '0);
    check_eq("mid.dataout", bus.DATAOUT, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
